// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: pipelined address/data phases, configurable wait states,
// byte lanes via HSIZE, INCR/WRAP burst tracking. Define AHB_SRAM_BURST_CHECK_EN to verify SEQ beats.
`timescale 1ns/1ps

module ahb_sram_slave #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int BYTES     = DATA_W / 8;
  localparam int LSB       = $clog2(BYTES);
  localparam int MEM_BYTES = DEPTH_WORDS * BYTES;
  localparam int AW        = $clog2(MEM_BYTES);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t              r_state;
  logic                r_hreadyout;
  logic                r_hresp;
  logic [DATA_W-1:0]   r_hrdata;
  logic [2:0]          r_wait_cnt;
  logic [AW-1:0]       r_addr;
  logic                r_write;
  logic [2:0]          r_size;

  logic                r_burst_active;
  logic                r_burst_incr;
  logic [3:0]          r_burst_cnt;

  logic [DATA_W-1:0]   r_mem [DEPTH_WORDS];

  logic                w_accept;
  logic                w_seq;
  logic [31:0]         w_inc;
  logic                w_err;
  logic                w_burst_err;
  logic [4:0]          w_beats;
  logic [LSB-1:0]      w_off;
  logic [BYTES-1:0]    w_be;
  logic [AW-LSB-1:0]   w_wr_idx;
  logic [AW-LSB-1:0]   w_rd_idx;
  logic                w_fwd;
  logic [DATA_W-1:0]   w_wr_word;
  logic [DATA_W-1:0]   w_rd_word;

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = r_hrdata;

  assign w_accept = HSEL & HREADY & HTRANS[1];
  assign w_seq    = (HTRANS == 2'b11);
  assign w_inc    = 32'd1 << HSIZE;

  always_comb begin
    case (HBURST[2:1])
      2'b01:   w_beats = 5'd4;
      2'b10:   w_beats = 5'd8;
      2'b11:   w_beats = 5'd16;
      default: w_beats = 5'd0;
    endcase
  end

`ifdef AHB_SRAM_BURST_CHECK_EN
  logic [31:0] r_exp_addr;
  logic [31:0] r_wrap_mask;
  logic        r_burst_wrap;
  logic [2:0]  r_burst_size;
  logic        r_burst_write;
  logic        w_wrap_now;
  logic [31:0] w_mask_now;
  logic [31:0] w_next_addr;

  // A SEQ beat inherits wrap geometry from its NONSEQ; a NONSEQ derives it from HBURST.
  assign w_wrap_now  = HTRANS[0] ? r_burst_wrap : (HBURST != 3'd0 && !HBURST[0]);
  assign w_mask_now  = HTRANS[0] ? r_wrap_mask : ((32'(w_beats) << HSIZE) - 32'd1);
  assign w_next_addr = w_wrap_now ? ((HADDR & ~w_mask_now) | ((HADDR + w_inc) & w_mask_now))
                                  : (HADDR + w_inc);
  // Overrun past a fixed-length burst lands on a closed tracker and trips the no-burst check.
  assign w_burst_err = w_seq && r_burst_active &&
                       (HADDR != r_exp_addr || HSIZE != r_burst_size || HWRITE != r_burst_write);
`else
  assign w_burst_err = 1'b0;
`endif

  assign w_err = (HSIZE > 3'(LSB))
               | (|(HADDR & (w_inc - 32'd1)))
               | (HADDR >= 32'(MEM_BYTES))
               | (w_seq && !r_burst_active)
               | w_burst_err;

  assign w_off    = r_addr[LSB-1:0];
  assign w_wr_idx = r_addr[AW-1:LSB];
  assign w_rd_idx = (r_state == ST_WAIT) ? r_addr[AW-1:LSB] : HADDR[AW-1:LSB];

  always_comb begin
    w_be = '0;
    for (int b = 0; b < BYTES; b++)
      w_be[b] = (b >= int'(w_off)) && (b < int'(w_off) + (1 << r_size));
  end

  always_comb begin
    w_wr_word = r_mem[w_wr_idx];
    for (int b = 0; b < BYTES; b++)
      if (w_be[b]) w_wr_word[8*b +: 8] = HWDATA[8*b +: 8];
  end

  // A zero-wait read accepted on the edge that commits a write to the same word sees the new bytes.
  assign w_fwd     = (r_state == ST_DATA) && r_write && (w_rd_idx == w_wr_idx);
  assign w_rd_word = w_fwd ? w_wr_word : r_mem[w_rd_idx];

  // NOTE: the array has no reset branch, so it maps onto plain SRAM; contents survive HRESETn.
  always_ff @(posedge HCLK) begin
    if (r_state == ST_DATA && r_write) begin
      for (int b = 0; b < BYTES; b++)
        if (w_be[b]) r_mem[w_wr_idx][8*b +: 8] <= HWDATA[8*b +: 8];
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
      r_wait_cnt  <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_size      <= '0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_wait_cnt == 3'd1) begin
            r_state     <= ST_DATA;
            r_hreadyout <= 1'b1;
            if (!r_write) r_hrdata <= w_rd_word;
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
        end
        default: begin
          if (HREADY) begin
            if (w_accept) begin
              r_addr  <= HADDR[AW-1:0];
              r_write <= HWRITE;
              r_size  <= HSIZE;
              if (w_err) begin
                r_state     <= ST_ERR1;
                r_hreadyout <= 1'b0;
                r_hresp     <= 1'b1;
              end else if (WAIT_STATES > 0) begin
                r_state     <= ST_WAIT;
                r_wait_cnt  <= 3'(WAIT_STATES);
                r_hreadyout <= 1'b0;
                r_hresp     <= 1'b0;
              end else begin
                r_state     <= ST_DATA;
                r_hreadyout <= 1'b1;
                r_hresp     <= 1'b0;
                if (!HWRITE) r_hrdata <= w_rd_word;
              end
            end else begin
              r_state     <= ST_IDLE;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_burst_active <= 1'b0;
      r_burst_incr   <= 1'b0;
      r_burst_cnt    <= '0;
`ifdef AHB_SRAM_BURST_CHECK_EN
      r_exp_addr     <= '0;
      r_wrap_mask    <= '0;
      r_burst_wrap   <= 1'b0;
      r_burst_size   <= '0;
      r_burst_write  <= 1'b0;
`endif
    end else if (w_accept) begin
      if (w_err) begin
        r_burst_active <= 1'b0;
      end else if (!HTRANS[0]) begin
        r_burst_active <= (HBURST != 3'd0);
        r_burst_incr   <= (HBURST == 3'd1);
        r_burst_cnt    <= (w_beats == 5'd0) ? 4'd0 : 4'(w_beats - 5'd1);
`ifdef AHB_SRAM_BURST_CHECK_EN
        r_exp_addr     <= w_next_addr;
        r_wrap_mask    <= w_mask_now;
        r_burst_wrap   <= w_wrap_now;
        r_burst_size   <= HSIZE;
        r_burst_write  <= HWRITE;
`endif
      end else begin
        if (!r_burst_incr) begin
          r_burst_cnt <= r_burst_cnt - 4'd1;
          if (r_burst_cnt == 4'd1) r_burst_active <= 1'b0;
        end
`ifdef AHB_SRAM_BURST_CHECK_EN
        r_exp_addr <= w_next_addr;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: a zero-wait and a two-wait instance share one master;
// the driver queues expected responses, a negedge monitor pops them at each data-phase completion.
`timescale 1ns/1ps

module tb_ahb_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        use2;

  logic        sel0, sel2, hready;
  logic        ro0, ro2, rs0, rs2;
  logic [31:0] rd0, rd2;
  logic        resp_m;
  logic [31:0] rdata_m;

`ifdef AHB_SRAM_BURST_CHECK_EN
  localparam bit BURST_CHK = 1'b1;
`else
  localparam bit BURST_CHK = 1'b0;
`endif

  assign sel0    = HSEL & ~use2;
  assign sel2    = HSEL & use2;
  assign hready  = use2 ? ro2 : ro0;
  assign resp_m  = use2 ? rs2 : rs0;
  assign rdata_m = use2 ? rd2 : rd0;

  always #5 HCLK = ~HCLK;

  ahb_sram_slave #(.DATA_W(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(hready),
    .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
  );

  ahb_sram_slave #(.DATA_W(32), .DEPTH_WORDS(256), .WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel2), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(hready),
    .HREADYOUT(ro2), .HRESP(rs2), .HRDATA(rd2)
  );

  typedef struct {
    string       name;
    bit          err;
    int          waits;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: counts stall cycles of each data phase and scores it on completion.
  bit dp_active    = 1'b0;
  bit saw_resp_low = 1'b0;
  int low_cnt      = 0;

  always @(negedge HCLK) begin
    if (dp_active) begin
      if (!hready) begin
        low_cnt++;
        if (resp_m) saw_resp_low = 1'b1;
      end else begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_data_phase: actual=completion required=none");
        end else begin
          m_e = q.pop_front();
          check({m_e.name, " waits"}, 32'(low_cnt), 32'(m_e.waits));
          check({m_e.name, " hresp"}, {31'b0, resp_m}, {31'b0, m_e.err});
          check({m_e.name, " err1"},  {31'b0, saw_resp_low}, {31'b0, m_e.err});
          if (m_e.chk) check({m_e.name, " hrdata"}, rdata_m, m_e.data);
        end
        dp_active = 1'b0;
      end
    end
    if (hready && HSEL && HTRANS[1]) begin
      dp_active    = 1'b1;
      low_cnt      = 0;
      saw_resp_low = 1'b0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge HCLK);
    while (!hready && n < 40) begin
      n++;
      @(negedge HCLK);
    end
    check("hready_timeout", {31'b0, hready}, 32'd1);
    @(posedge HCLK);
    #1;
  endtask

  task automatic issue(input logic [1:0] tr, input logic [31:0] addr, input logic wr,
                       input logic [2:0] sz, input logic [2:0] bu, input logic [31:0] wd,
                       input bit err, input bit chk, input logic [31:0] rd, input string name);
    exp_t e;
    HSEL   = 1'b1;
    HTRANS = tr;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = sz;
    HBURST = bu;
    wait_ready();
    HWDATA = wd;
    if (tr[1]) begin
      e.name  = name;
      e.err   = err;
      e.waits = err ? 1 : (use2 ? 2 : 0);
      e.chk   = chk;
      e.data  = rd;
      q.push_back(e);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz, input string nm);
    issue(2'b10, a, 1'b1, sz, 3'd0, d, 1'b0, 1'b0, 32'h0, nm);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] x, input string nm);
    issue(2'b10, a, 1'b0, 3'd2, 3'd0, 32'h0, 1'b0, 1'b1, x, nm);
  endtask

  task automatic idle();
    issue(2'b00, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, "idle");
  endtask

  initial begin
    HRESETn = 1'b0;
    HSEL    = 1'b0;
    HTRANS  = 2'b00;
    HADDR   = '0;
    HWRITE  = 1'b0;
    HSIZE   = 3'd2;
    HBURST  = 3'd0;
    HWDATA  = '0;
    use2    = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst ws0 hreadyout", {31'b0, ro0}, 32'd1);
    check("rst ws0 hresp",     {31'b0, rs0}, 32'd0);
    check("rst ws0 hrdata",    rd0,          32'h0);
    check("rst ws2 hreadyout", {31'b0, ro2}, 32'd1);
    check("rst ws2 hresp",     {31'b0, rs2}, 32'd0);
    check("rst ws2 hrdata",    rd2,          32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Zero-wait slave: back-to-back write/read with forwarding, sub-word lanes.
    wr(32'h10, 32'hDEADBEEF, 3'd2, "w10");
    rd(32'h10, 32'hDEADBEEF, "r10_raw");
    wr(32'h10, 32'h11223344, 3'd2, "w10b");
    wr(32'h13, 32'hAA000000, 3'd0, "wbyte13");
    rd(32'h10, 32'hAA223344, "r10_byte");
    wr(32'h14, 32'h55667788, 3'd2, "w14");
    wr(32'h16, 32'hBEEF0000, 3'd1, "whalf16");
    rd(32'h14, 32'hBEEF7788, "r14_half");

    // WRAP4 write from 0x38, read back as INCR4 from 0x30.
    issue(2'b10, 32'h38, 1'b1, 3'd2, 3'd2, 32'd1, 1'b0, 1'b0, 32'h0, "wrap_b0");
    issue(2'b11, 32'h3C, 1'b1, 3'd2, 3'd2, 32'd2, 1'b0, 1'b0, 32'h0, "wrap_b1");
    issue(2'b11, 32'h30, 1'b1, 3'd2, 3'd2, 32'd3, 1'b0, 1'b0, 32'h0, "wrap_b2");
    issue(2'b11, 32'h34, 1'b1, 3'd2, 3'd2, 32'd4, 1'b0, 1'b0, 32'h0, "wrap_b3");
    issue(2'b10, 32'h30, 1'b0, 3'd2, 3'd3, 32'h0, 1'b0, 1'b1, 32'd3, "rinc_30");
    issue(2'b11, 32'h34, 1'b0, 3'd2, 3'd3, 32'h0, 1'b0, 1'b1, 32'd4, "rinc_34");
    issue(2'b11, 32'h38, 1'b0, 3'd2, 3'd3, 32'h0, 1'b0, 1'b1, 32'd1, "rinc_38");
    issue(2'b11, 32'h3C, 1'b0, 3'd2, 3'd3, 32'h0, 1'b0, 1'b1, 32'd2, "rinc_3c");

    // Error responses leave memory untouched.
    wr(32'h00, 32'hCAFEF00D, 3'd2, "w00");
    issue(2'b10, 32'h01,  1'b1, 3'd1, 3'd0, 32'h12345678, 1'b1, 1'b0, 32'h0, "err_misalign");
    issue(2'b10, 32'h400, 1'b1, 3'd2, 3'd0, 32'h99999999, 1'b1, 1'b0, 32'h0, "err_range");
    issue(2'b10, 32'h08,  1'b1, 3'd3, 3'd0, 32'h55555555, 1'b1, 1'b0, 32'h0, "err_size");
    issue(2'b11, 32'h04,  1'b1, 3'd2, 3'd1, 32'h66666666, 1'b1, 1'b0, 32'h0, "err_seq_noburst");
    rd(32'h00, 32'hCAFEF00D, "r00_after_err");

    // INCR4 with a skipped beat address.
    wr(32'h0C, 32'h77777777, 3'd2, "w0c");
    issue(2'b10, 32'h00, 1'b1, 3'd2, 3'd3, 32'hA1A1A1A1, 1'b0, 1'b0, 32'h0, "incr4_b0");
    issue(2'b11, 32'h04, 1'b1, 3'd2, 3'd3, 32'hA2A2A2A2, 1'b0, 1'b0, 32'h0, "incr4_b1");
    issue(2'b11, 32'h0C, 1'b1, 3'd2, 3'd3, 32'hA3A3A3A3, BURST_CHK, 1'b0, 32'h0, "incr4_skip");
    idle();
    rd(32'h00, 32'hA1A1A1A1, "r00_incr4");
    rd(32'h04, 32'hA2A2A2A2, "r04_incr4");
    rd(32'h0C, BURST_CHK ? 32'h77777777 : 32'hA3A3A3A3, "r0c_incr4");
    idle();

    // Two-wait slave.
    use2 = 1'b1;
    wr(32'h20, 32'h0BADCAFE, 3'd2, "ws2_w20");
    idle();
    rd(32'h20, 32'h0BADCAFE, "ws2_r20");
    wr(32'h24, 32'h13579BDF, 3'd2, "ws2_w24");
    wr(32'h25, 32'h0000EE00, 3'd0, "ws2_wbyte25");
    rd(32'h24, 32'h1357EEDF, "ws2_r24_raw");
    issue(2'b10, 32'h21, 1'b1, 3'd1, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0, "ws2_err_misalign");
    rd(32'h20, 32'h0BADCAFE, "ws2_r20_after_err");
    idle();

    repeat (3) @(posedge HCLK);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- Parametrised AHB-Lite slave SRAM; successor to the single-word burst memory model.
- Proper address/data phase pipelining, HSEL decode, HREADYOUT with configurable wait states, and byte/halfword/word lanes via HSIZE.
- Tracks INCR/WRAP bursts; returns the two-cycle AHB ERROR response.
- Sits behind the interconnect as a bus-test memory endpoint.

Parameters:
- DATA_W, 32, data bus width in bits; 32 or 64.
- DEPTH_WORDS, 256, memory depth in DATA_W words; power of two.
- WAIT_STATES, 0, wait cycles (HREADYOUT=0) inserted in every OKAY data phase; 0..7.

Ports:
- HCLK  in  1  clock, all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address; only low log2(DEPTH_WORDS*DATA_W/8) bits index memory.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1=write.
- HSIZE  in  3  bytes = 2^HSIZE.
- HBURST  in  3  SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- HWDATA  in  DATA_W  write data, valid in data phase.
- HREADY  in  1  bus-wide ready; address phase accepted only when 1.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  DATA_W  read data, valid when HREADYOUT=1 in a read data phase.

Behaviour:
- Reset (asynchronous, HRESETn=0): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, burst tracker cleared. Memory contents not reset.
- Address phase accepted on a rising edge with HSEL=1, HREADY=1, HTRANS[1]=1. Captures addr, write, size, burst.
- IDLE/BUSY, or HSEL=0, with HREADY=1: next cycle zero-wait OKAY. No memory access.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
- Accepted transfer, error-free:
  - WAIT_STATES>0: go to WAIT, counter=WAIT_STATES, HREADYOUT=0.
  - Counter decrements each cycle; at 1, go to DATA.
  - WAIT_STATES=0: go directly to DATA.
  - DATA drives HREADYOUT=1, HRESP=0. Next state from the current bus (pipelined back-to-back).
- Error checks (any one → ERR1):
  - HSIZE > log2(DATA_W/8).
  - Address not aligned to HSIZE.
  - Address ≥ DEPTH_WORDS*DATA_W/8.
  - SEQ with no active burst.
- ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1. No memory access. Burst tracker cleared.
- Write: HWDATA lanes selected by addr low bits and size; committed on the edge ending DATA. Unselected bytes are unchanged.
- Read: HRDATA loaded with the full addressed word on the edge entering DATA; all lanes driven.
- Read-after-write hazard: a read whose data phase follows a write to the same word returns the newly written bytes (bypass/forward), with any WAIT_STATES.
- Burst tracker:
  - NONSEQ with HBURST≠SINGLE opens a burst: count = 4/8/16 beats (INCR: unbounded).
  - Each accepted SEQ decrements the count; at 0 the burst closes.
  - WRAP boundary = beats*2^HSIZE; expected next address wraps within it.
  - A new NONSEQ closes any open burst. BUSY holds burst state.
- Reset mid-transfer aborts immediately; no partial write.

Optional Feature:
- Macro AHB_SRAM_BURST_CHECK_EN.
- Defined: every SEQ is checked against the tracker's expected address (INCR or WRAP computed) and against the HSIZE/HWRITE captured at NONSEQ. Mismatch → ERR1/ERR2. Fixed-length overrun (SEQ after count reaches 0) → error.
- Undefined: SEQ addresses used as presented. Only the no-active-burst SEQ error remains.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF @0x10, then read 0x10 back-to-back → HRDATA=0xDEADBEEF, HREADYOUT always 1, HRESP=0.
- WAIT_STATES=2: single read @0x20 → HREADYOUT low exactly 2 cycles, then high with data, HRESP=0.
- Byte write 0xAA @0x13 (HSIZE=0) onto word 0x11223344 → read 0x10 returns 0xAA223344.
- WRAP4 word write starting 0x38 (0x38,0x3C,0x30,0x34) with data 1..4 → reads return 3,4,1,2 at 0x30..0x3C.
- Halfword @0x01, then address 0x400 (DEPTH_WORDS=256) → each gives HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; memory unchanged.
- Macro defined: INCR4 at 0x00 with second SEQ at 0x0C instead of 0x08 → ERROR on that beat; without macro → OKAY write to 0x0C.
